clock_enable_sequencer: RTL and testbench

Parametrised clock-enable generator and reset sequencer for the FPGA top level. It runs on the single PLL output clock and produces `CHANNELS` phase-aligned, run-time-programmable clock-enable strobes, so the design no longer needs divided (ripple) clocks. It holds the system reset (CPU6, Memory, LEDPanel) until PLL lock has been stable for a programmable interval, and re-enters reset if lock is lost.

---
 rtl/clock_enable_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_clock_enable_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/clock_enable_sequencer.sv
// -----------------------------------------------------------------------------
// clock_enable_sequencer
//
// Single-clock enable generator and reset sequencer for the FPGA top level.
// It produces CHANNELS phase-aligned, run-time programmable clock-enable
// strobes, so the design needs no divided clocks. It also holds the
// downstream system reset until PLL lock has been stable for LOCK_CYCLES
// cycles, and then for a further RESET_HOLD cycles.
//
// Ports:
//   clock      in   only clock (PLL output)
//   reset      in   asynchronous active-low reset
//   locked     in   PLL lock, asynchronous to clock (synchronised internally)
//   divisor    in   CHANNELS*DIV_WIDTH; channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   load       in   one-cycle pulse capturing divisor into the pending registers
//   enable     out  CHANNELS one-cycle enable strobes (registered)
//   sys_reset  out  active-high reset for downstream logic (registered)
//   ready      out  high while running normally (registered)
// -----------------------------------------------------------------------------
module clock_enable_sequencer #(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int RESET_HOLD  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          locked,
  input  logic [CHANNELS*DIV_WIDTH-1:0] divisor,
  input  logic                          load,
  output logic [CHANNELS-1:0]           enable,
  output logic                          sys_reset,
  output logic                          ready
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam logic [LOCK_W-1:0]    LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST   = DIV_WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                sync1_r;
  logic                locked_s;
  logic [LOCK_W-1:0]   lock_cnt_r;
  logic [LOCK_W-1:0]   lock_cnt_next_s;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [HOLD_W-1:0]   hold_cnt_next_s;
  logic                running_s;
  logic                running_next_s;
  logic [CHANNELS-1:0] en_next_s;

  // Two-flop synchroniser bringing the PLL lock into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_r  <= locked;
      locked_s <= sync1_r;
    end
  end

  // Sequencer next-state logic; any lock loss after WAIT_LOCK restarts it.
  always_comb begin
    next_state_s    = state_r;
    lock_cnt_next_s = lock_cnt_r;
    hold_cnt_next_s = hold_cnt_r;
    case (state_r)
      WAIT_LOCK: begin
        lock_cnt_next_s = '0;
        if (locked_s) begin
          next_state_s = STABLE;
        end else begin
          next_state_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          next_state_s    = WAIT_LOCK;
          lock_cnt_next_s = '0;
        end else if (lock_cnt_r == LOCK_LAST) begin
          next_state_s    = HOLD;
          lock_cnt_next_s = '0;
          hold_cnt_next_s = '0;
        end else begin
          lock_cnt_next_s = lock_cnt_r + LOCK_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          next_state_s    = WAIT_LOCK;
          hold_cnt_next_s = '0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          next_state_s    = RUN;
          hold_cnt_next_s = '0;
        end else begin
          hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          next_state_s = WAIT_LOCK;
        end else begin
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s    = WAIT_LOCK;
        lock_cnt_next_s = '0;
        hold_cnt_next_s = '0;
      end
    endcase
  end

  assign running_s      = (state_r == HOLD) || (state_r == RUN);
  assign running_next_s = (next_state_s == HOLD) || (next_state_s == RUN);

  // Per-channel divisor registers and phase counter.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [DIV_WIDTH-1:0] pend_r;
    logic [DIV_WIDTH-1:0] div_r;
    logic [DIV_WIDTH-1:0] cnt_r;
    logic [DIV_WIDTH-1:0] div_in_s;
    logic [DIV_WIDTH-1:0] pend_next_s;
    logic [DIV_WIDTH-1:0] div_next_s;
    logic [DIV_WIDTH-1:0] cnt_next_s;
    logic                 wrap_s;

    assign div_in_s = divisor[i*DIV_WIDTH +: DIV_WIDTH];
    // The counter is at its terminal value exactly in this channel's strobe cycle.
    assign wrap_s   = (cnt_r == div_r);

    // Divisor hand-over and counter stepping; divisors only change at a wrap
    // while running, so no period is ever truncated or stretched.
    always_comb begin
      pend_next_s = pend_r;
      div_next_s  = div_r;
      cnt_next_s  = '0;
      if (load) begin
        pend_next_s = div_in_s;
      end else begin
        pend_next_s = pend_r;
      end
      if (running_s) begin
        if (wrap_s) begin
          // A load coinciding with the wrap takes effect at this wrap.
          if (load) begin
            div_next_s = div_in_s;
          end else begin
            div_next_s = pend_r;
          end
        end else begin
          div_next_s = div_r;
        end
      end else begin
        div_next_s = pend_r;
      end
      if (running_s && running_next_s) begin
        if (wrap_s) begin
          cnt_next_s = '0;
        end else begin
          cnt_next_s = cnt_r + DIV_WIDTH'(1);
        end
      end else begin
        cnt_next_s = '0;
      end
    end

    // Strobe is registered: it is high for the cycle whose count equals the divisor.
    assign en_next_s[i] = running_next_s && (cnt_next_s == div_next_s);

    // Channel register bank.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pend_r <= DIV_RST;
        div_r  <= DIV_RST;
        cnt_r  <= '0;
      end else begin
        pend_r <= pend_next_s;
        div_r  <= div_next_s;
        cnt_r  <= cnt_next_s;
      end
    end
  end

  // State, sequencing counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= WAIT_LOCK;
      lock_cnt_r <= '0;
      hold_cnt_r <= '0;
      enable     <= '0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      lock_cnt_r <= lock_cnt_next_s;
      hold_cnt_r <= hold_cnt_next_s;
      enable     <= en_next_s;
      sys_reset  <= (next_state_s != RUN);
      ready      <= (next_state_s == RUN);
    end
  end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_sequencer
//
// Directed self-checking bench for clock_enable_sequencer with CHANNELS=2,
// DIV_WIDTH=4, LOCK_CYCLES=8, RESET_HOLD=4, DEFAULT_DIV=3. Edge k is the k-th
// rising edge after locked is presented; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_clock_enable_sequencer;

  logic       clock;
  logic       reset;
  logic       locked;
  logic [7:0] divisor;
  logic       load;
  logic [1:0] enable;
  logic       sys_reset;
  logic       ready;

  int n_cmp;
  int n_bad;

  clock_enable_sequencer #(
    .CHANNELS   (2),
    .DIV_WIDTH  (4),
    .DEFAULT_DIV(3),
    .LOCK_CYCLES(8),
    .RESET_HOLD (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .locked   (locked),
    .divisor  (divisor),
    .load     (load),
    .enable   (enable),
    .sys_reset(sys_reset),
    .ready    (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_all(input string ph, input int k, input logic [1:0] en_x,
                         input logic srst_x, input logic rdy_x);
    chk($sformatf("%s_enable@%0d", ph, k), {6'b0, enable}, {6'b0, en_x});
    chk($sformatf("%s_sys_reset@%0d", ph, k), {7'b0, sys_reset}, {7'b0, srst_x});
    chk($sformatf("%s_ready@%0d", ph, k), {7'b0, ready}, {7'b0, rdy_x});
  endtask

  initial begin
    logic [1:0] en_x;
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    locked  = 1'b0;
    load    = 1'b0;
    divisor = 8'h00;

    // Reset state while reset is held low.
    #12;
    chk_all("reset", 0, 2'b00, 1'b1, 1'b0);

    // Power-up with default divisors, then a run-time load of {ch1=9, ch0=1}.
    @(negedge clock);
    reset  = 1'b1;
    locked = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      if (k == 24) begin
        divisor = 8'h91;
        load    = 1'b1;
      end
      tick();
      load = 1'b0;
      if (k < 10) begin
        en_x = 2'b00;
      end else if (k <= 25) begin
        en_x = (((k - 10) % 4) == 3) ? 2'b11 : 2'b00;
      end else begin
        en_x[0] = (k >= 27) && (((k - 27) % 2) == 0);
        en_x[1] = (k == 35) || (k == 45);
      end
      chk_all("pwr", k, en_x, (k < 14), (k >= 14));
    end

    // Asynchronous reset between edges while both strobes are high.
    #1;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 0, 2'b00, 1'b1, 1'b0);

    // Restart with lock already present; divisors must be back to 3.
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      chk_all("restart", k, (k == 13) ? 2'b11 : 2'b00, (k < 14), (k >= 14));
    end

    // One-cycle lock loss in RUN, then the full sequence again.
    locked = 1'b0;
    for (int k = 17; k <= 33; k++) begin
      tick();
      locked = 1'b1;
      en_x = ((k == 17) || (k == 31)) ? 2'b11 : 2'b00;
      chk_all("lockloss", k, en_x, (k >= 19) && (k < 32), (k < 19) || (k >= 32));
    end

    // Divisors 0/5 loaded in WAIT_LOCK, then a lock glitch at lock count 5.
    locked = 1'b0;
    #1;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    divisor = 8'h50;
    load    = 1'b1;
    @(negedge clock);
    load   = 1'b0;
    locked = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      if (k == 6) begin
        locked = 1'b0;
      end else begin
        locked = 1'b1;
      end
      tick();
      en_x[0] = (k >= 17);
      en_x[1] = (k >= 17) && (((k - 17) % 6) == 5);
      chk_all("glitch", k, en_x, (k < 21), (k >= 21));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
